// File: rtl/sbldc_uart_pkg.sv
// Shared definitions for the SBLDC UART transmitter and receiver:
// frame states, baud-select codes and the default clocks-per-bit divisors.
package sbldc_uart_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam logic [2:0] BC_CODE0 = 3'b000;
  localparam logic [2:0] BC_CODE1 = 3'b001;
  localparam logic [2:0] BC_CODE2 = 3'b010;
  localparam logic [2:0] BC_CODE3 = 3'b011;
  localparam logic [2:0] BC_CODE4 = 3'b100;

  // Clocks per bit at 50 MHz; DIV0 is 115200 baud and the fallback rate.
  localparam int DEFAULT_DIV0 = 434;
  localparam int DEFAULT_DIV1 = 217;
  localparam int DEFAULT_DIV2 = 109;
  localparam int DEFAULT_DIV3 = 72;
  localparam int DEFAULT_DIV4 = 36;

endpackage

// File: rtl/sbldc_uart_baud_gen.sv
// Bit-period timer: selects a divisor from BC, latches it when a frame is
// loaded and pulses tick on the last clock of every bit period.
module sbldc_uart_baud_gen
  import sbldc_uart_pkg::*;
#(
  parameter int DIV0 = DEFAULT_DIV0,
  parameter int DIV1 = DEFAULT_DIV1,
  parameter int DIV2 = DEFAULT_DIV2,
  parameter int DIV3 = DEFAULT_DIV3,
  parameter int DIV4 = DEFAULT_DIV4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] BC,
  input  logic       load,
  input  logic       clear,
  output logic       tick
);

  logic [DIV_W-1:0] div_sel;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  always_comb begin
    div_sel = DIV_W'(DIV0);
    case (BC)
      BC_CODE1: div_sel = DIV_W'(DIV1);
      BC_CODE2: div_sel = DIV_W'(DIV2);
      BC_CODE3: div_sel = DIV_W'(DIV3);
      BC_CODE4: div_sel = DIV_W'(DIV4);
      default:  div_sel = DIV_W'(DIV0);
    endcase
  end

  assign tick = ~clear & (cnt_q == (div_q - DIV_W'(1)));

  // The counter restarts on every bit boundary so each level lasts div_q clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= DIV_W'(DIV0);
      cnt_q <= '0;
    end else begin
      if (load) begin
        div_q <= div_sel;
      end
      if (clear || load || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sbldc_uart_tx.sv
// UART transmitter for motor-controller command bytes: 8N1, LSB first,
// with a far-end abort (Mreset) that returns the line to idle at once.
module sbldc_uart_tx
  import sbldc_uart_pkg::*;
#(
  parameter int DIV0 = DEFAULT_DIV0,
  parameter int DIV1 = DEFAULT_DIV1,
  parameter int DIV2 = DEFAULT_DIV2,
  parameter int DIV3 = DEFAULT_DIV3,
  parameter int DIV4 = DEFAULT_DIV4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] BC,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  input  logic       Mreset,
  output logic       Ready,
  output logic       Busy,
  output logic       Tx_out
);

  localparam logic [1:0] IDLE  = UART_IDLE;
  localparam logic [1:0] START = UART_START;
  localparam logic [1:0] DATA  = UART_DATA;
  localparam logic [1:0] STOP  = UART_STOP;

  logic [1:0] state_q;
  logic [7:0] data_q;
  logic [2:0] bit_idx;
  logic       tx_q;
  logic       ready_en;
  logic       accept;
  logic       tick;
  logic       baud_clear;

  // ready_en keeps Ready low until the first clock edge after reset release.
  assign Ready      = (state_q == IDLE) & ~Mreset & ready_en;
  assign Busy       = (state_q != IDLE);
  assign Tx_out     = tx_q;
  assign accept     = DataValid & Ready;
  assign baud_clear = (state_q == IDLE) | Mreset;

  sbldc_uart_baud_gen #(
    .DIV0 (DIV0),
    .DIV1 (DIV1),
    .DIV2 (DIV2),
    .DIV3 (DIV3),
    .DIV4 (DIV4)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .BC    (BC),
    .load  (accept),
    .clear (baud_clear),
    .tick  (tick)
  );

  // Tx_out is registered: each level change is scheduled on the edge that
  // ends the previous bit, so the start bit appears right after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= 8'h00;
      bit_idx  <= 3'd0;
      tx_q     <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (Mreset) begin
        state_q <= IDLE;
        bit_idx <= 3'd0;
        tx_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= START;
              data_q  <= DataIn;
              bit_idx <= 3'd0;
              tx_q    <= 1'b0;
            end
          end
          START: begin
            if (tick) begin
              state_q <= DATA;
              bit_idx <= 3'd0;
              tx_q    <= data_q[0];
            end
          end
          DATA: begin
            if (tick) begin
              if (bit_idx == 3'd7) begin
                state_q <= STOP;
                bit_idx <= 3'd0;
                tx_q    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_q    <= data_q[bit_idx + 3'd1];
              end
            end
          end
          STOP: begin
            if (tick) begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sbldc_uart_tx.sv
// Self-checking bench for sbldc_uart_tx: random bytes are compared bit-period
// by bit-period against an ideal 8N1 line waveform built from the byte value.
module tb_sbldc_uart_tx;

  logic       clk;
  logic       reset;
  logic [2:0] BC;
  logic [7:0] DataIn;
  logic       DataValid;
  logic       Mreset;
  logic       Ready;
  logic       Busy;
  logic       Tx_out;

  int asserts  = 0;
  int failures = 0;

  sbldc_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .BC        (BC),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .Mreset    (Mreset),
    .Ready     (Ready),
    .Busy      (Busy),
    .Tx_out    (Tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input logic [2:0] bc);
    case (bc)
      3'b001:  return 217;
      3'b010:  return 109;
      3'b011:  return 72;
      3'b100:  return 36;
      default: return 434;
    endcase
  endfunction

  // Called at a negedge with the transmitter idle; checks a whole frame,
  // then the single idle cycle that follows the stop bit.
  task automatic xmit(input logic [7:0] b, input logic [2:0] bc, input bit hold,
                      input logic [7:0] mid_data, input logic [2:0] mid_bc);
    int         div;
    logic [9:0] frame;
    bit         bad;
    logic       got_tx, got_busy, got_ready;
    int         bad_cycle;
    div   = div_of(bc);
    frame = {1'b1, b, 1'b0};
    DataIn    = b;
    BC        = bc;
    DataValid = 1'b1;
    asserts++;
    if (Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_ready byte=%h: Ready=%b expected 1", b, Ready);
    end
    @(negedge clk);
    if (!hold) DataValid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bad = 1'b0;
      got_tx = 1'bx; got_busy = 1'bx; got_ready = 1'bx; bad_cycle = 0;
      for (int c = 0; c < div; c++) begin
        if (j != 0 || c != 0) @(negedge clk);
        if (j == 5 && c == 0) begin
          DataIn = mid_data;
          BC     = mid_bc;
        end
        if (!bad && (Tx_out !== frame[j] || Busy !== 1'b1 || Ready !== 1'b0)) begin
          bad = 1'b1;
          got_tx = Tx_out; got_busy = Busy; got_ready = Ready; bad_cycle = c;
        end
      end
      asserts++;
      if (bad) begin
        failures++;
        $display("[TB] FAIL frame_bit byte=%h div=%0d bit=%0d cycle=%0d: Tx=%b Busy=%b Ready=%b expected Tx=%b Busy=1 Ready=0",
                 b, div, j, bad_cycle, got_tx, got_busy, got_ready, frame[j]);
      end
    end
    @(negedge clk);
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gap_idle byte=%h: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=1",
               b, Tx_out, Busy, Ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; BC = 3'b000; DataIn = 8'h00; DataValid = 1'b0; Mreset = 1'b0;
    #12;
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=0",
               Tx_out, Busy, Ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    asserts++;
    if (Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_before_edge: Ready=%b expected 0", Ready);
    end
    @(negedge clk);
    asserts++;
    if (Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_edge: Ready=%b expected 1", Ready);
    end
  endtask

  task automatic test_a5();
    xmit(8'hA5, 3'b000, 1'b0, 8'($urandom), 3'b000);
  endtask

  task automatic test_back_to_back();
    xmit(8'h00, 3'b100, 1'b1, 8'hFF, 3'b100);
    xmit(8'hFF, 3'b100, 1'b1, 8'h00, 3'b100);
    for (int i = 0; i < 3; i++) begin
      xmit(8'($urandom), 3'b100, (i != 2), 8'($urandom), 3'b100);
    end
  endtask

  task automatic test_bc_change();
    xmit(8'($urandom), 3'b000, 1'b0, 8'($urandom), 3'b001);
    xmit(8'($urandom), 3'b001, 1'b0, 8'($urandom), 3'b010);
    xmit(8'($urandom), 3'b110, 1'b0, 8'($urandom), 3'b100);
  endtask

  task automatic test_mreset_data();
    logic [7:0] b;
    b = 8'($urandom);
    DataIn = b; BC = 3'b100; DataValid = 1'b1;
    @(negedge clk);
    DataValid = 1'b0;
    repeat (4 * 36 + 10) @(negedge clk);
    asserts++;
    if (Tx_out !== b[3] || Busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mreset_pre_bit3: Tx=%b Busy=%b expected Tx=%b Busy=1", Tx_out, Busy, b[3]);
    end
    Mreset = 1'b1;
    #1;
    asserts++;
    if (Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mreset_ready: Ready=%b expected 0", Ready);
    end
    @(negedge clk);
    Mreset = 1'b0;
    #1;
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mreset_abort: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=1",
               Tx_out, Busy, Ready);
    end
    xmit(8'($urandom), 3'b100, 1'b0, 8'($urandom), 3'b100);
  endtask

  task automatic test_mreset_valid();
    bit bad;
    bad = 1'b0;
    Mreset = 1'b1; DataValid = 1'b1; DataIn = 8'($urandom); BC = 3'b100;
    #1;
    asserts++;
    if (Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mreset_valid_ready: Ready=%b expected 0", Ready);
    end
    repeat (4) begin
      @(negedge clk);
      if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b0) bad = 1'b1;
    end
    asserts++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL mreset_valid_hold: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=0",
               Tx_out, Busy, Ready);
    end
    Mreset = 1'b0; DataValid = 1'b0;
    @(negedge clk);
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mreset_valid_release: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=1",
               Tx_out, Busy, Ready);
    end
  endtask

  task automatic test_reset_in_stop();
    DataIn = 8'($urandom); BC = 3'b011; DataValid = 1'b1;
    @(negedge clk);
    DataValid = 1'b0;
    repeat (9 * 72 + 20) @(negedge clk);
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stop_before_reset: Tx=%b Busy=%b expected Tx=1 Busy=1", Tx_out, Busy);
    end
    #2 reset = 1'b0;
    #1;
    asserts++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 || Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_stop: Tx=%b Busy=%b Ready=%b expected Tx=1 Busy=0 Ready=0",
               Tx_out, Busy, Ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xmit(8'h3C, 3'b011, 1'b0, 8'($urandom), 3'b000);
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_bc_change();
    test_mreset_data();
    test_mreset_valid();
    test_reset_in_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/sbldc_uart_tx.md
SBLDC_UART_TX -- requirements
Module: sbldc_uart_tx

Interface
REQ-001 Parameter DIV0, default 434: clocks per bit when BC is 3'b000 or any unlisted code (115200 baud at 50 MHz).
REQ-002 Parameter DIV1, default 217: clocks per bit when BC is 3'b001.
REQ-003 Parameter DIV2, default 109: clocks per bit when BC is 3'b010.
REQ-004 Parameter DIV3, default 72: clocks per bit when BC is 3'b011.
REQ-005 Parameter DIV4, default 36: clocks per bit when BC is 3'b100.
REQ-006 Port clk, input, 1: single 50 MHz clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: asynchronous active-low reset.
REQ-008 Port BC, input, 3: baud-rate selection, sampled only at frame acceptance.
REQ-009 Port DataIn, input, 8: command byte for the motor controller.
REQ-010 Port DataValid, input, 1: DataIn holds a byte to send.
REQ-011 Port Mreset, input, 1: synchronous abort request from the far-end receiver.
REQ-012 Port Ready, output, 1: transmitter can accept a byte this cycle.
REQ-013 Port Busy, output, 1: a frame is in progress (state not IDLE).
REQ-014 Port Tx_out, output, 1: serial line; idle level is high.

Function
REQ-015 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 Ready SHALL equal (state==IDLE) & ~Mreset.
REQ-018 A byte SHALL be accepted on an edge where DataValid & Ready; DataIn and the BC-derived divisor latch on that edge, and the state goes to START.
REQ-019 Tx_out SHALL be registered; it goes low on the acceptance edge, so the start bit is visible from the first cycle after acceptance.
REQ-020 Each bit SHALL be held for exactly DIV clocks, timed by a bit-tick counter counting 0..DIV-1; a tick occurs at DIV-1.
REQ-021 START→DATA at the first tick; DATA holds for 8 ticks via a 3-bit index 0..7, then →STOP; STOP→IDLE at its tick.
REQ-022 A frame SHALL occupy exactly 10*DIV cycles of Tx_out.
REQ-023 With DataValid held high, the gap between frames SHALL be exactly 1 idle-high cycle (the IDLE cycle in which Ready is high).
REQ-024 Changes on BC or DataIn during a frame SHALL NOT affect that frame.
REQ-025 Mreset high on any edge SHALL force the next state to IDLE, set Tx_out=1, and clear the counters and bit index.
REQ-026 If Mreset and DataValid are high on the same edge, Mreset SHALL win and the byte is not accepted.
REQ-027 Busy SHALL be high exactly in START, DATA and STOP.

Reset
REQ-028 While reset=0: state=IDLE, Tx_out=1, Busy=0, Ready=0, counters=0, latched data=8'h00, latched divisor=DIV0.
REQ-029 Ready SHALL go high on the first clk edge after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL immediately (asynchronously) return Tx_out to 1 with no partial bit completed.

Structure
REQ-031 Package sbldc_uart_pkg SHALL hold the state enum, the BC code constants and the DIV0..DIV4 defaults; the receiver shares them.
REQ-032 Sub-module sbldc_uart_baud_gen SHALL contain the divisor mux, the latched divisor and the bit-tick counter, with inputs clk, reset, BC, load and clear, and output tick.

Verification
REQ-033 BC=000, send 8'hA5 → Tx_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 434 cycles; 4340 cycles total; Ready low for the whole frame.
REQ-034 BC=100, DataValid held with 8'h00 then 8'hFF → each bit lasts 36 cycles; exactly 1 high cycle between the stop bit and the next start bit.
REQ-035 BC changed from 000 to 001 mid-frame → the current frame stays at 434 cycles per bit; the next frame uses 217 cycles per bit.
REQ-036 Mreset pulsed for 1 cycle during DATA bit 3 → Tx_out=1 and Busy=0 on the next cycle; Ready returns the cycle after Mreset falls; the next byte is sent cleanly.
REQ-037 Mreset=1 and DataValid=1 in IDLE → no start bit is issued and Ready=0.
REQ-038 reset asserted in STOP → Tx_out=1 and Busy=0 asynchronously; after release, 8'h3C is sent correctly at BC=011 with 72 cycles per bit.
